tpram_fifo_ctrl: RTL and testbench
==================================

# tpram_fifo_ctrl

Synchronous FIFO controller that turns one `std_tpram64x288` two-port SRAM into a 64-deep, 288-bit valid/ready stream buffer with a 2-entry output prefetch stage. It owns both RAM ports: write pointer, read pointer and occupancy. It also hides the one-cycle registered RAM read latency, so the consumer sees a plain valid/ready interface at full throughput. The block sits between an NPU datapath producer (e.g. a psum/feature writer) and its consumer, with the SRAM wrapper instantiated alongside it at the same level.

## Interface
- `DW`, 288, data width (must match the RAM word).
- `AW`, 6, RAM address width.
- `DEPTH`, 64, RAM entries (= 2^AW).
- `clk`  in  1  single clock; drives the RAM's `RCLK` and `WCLK`.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  synchronous clear of all contents.
- `in_valid`  in  1  producer data valid.
- `in_ready`  out  1  producer may transfer; registered.
- `in_data`  in  DW  producer data.
- `out_valid`  out  1  head entry valid; registered.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  DW  head entry; registered.
- `level`  out  7  total entries held = RAM count + read in flight + prefetch count; range 0..66.
- `ram_wceb`  out  1  RAM write enable, active-low.
- `ram_waddr`  out  AW  RAM write address.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rceb`  out  1  RAM read enable, active-low.
- `ram_raddr`  out  AW  RAM read address.
- `ram_rdata`  in  DW  RAM read data; valid in the cycle after `ram_rceb` is low.

## Operation
- **Write side**
  - `in_fire = in_valid & in_ready`.
  - `ram_wceb = ~in_fire`, `ram_waddr = wptr`, `ram_wdata = in_data` (combinational).
  - `wptr` increments mod 64 on every `in_fire`.
  - `in_ready` is registered as `ram_cnt_next < DEPTH`.
- **RAM count**
  - `ram_cnt` (0..64) increments on `in_fire` and decrements on read issue; simultaneous write and issue leave it unchanged.
  - A word written at edge E can be read no earlier than the cycle after E. This avoids read-during-write on the same address.
- **Read issue**
  - Issue when `ram_cnt > 0 & ~flush & (ob_cnt + rd_pend - out_fire) <= 1`.
  - On issue: `ram_rceb = 0`, `ram_raddr = rptr`, `rptr` increments mod 64, and `rd_pend` is set for the next cycle.
  - The issue condition depends combinationally on `out_ready`.
- **Capture**
  - In a cycle where `rd_pend = 1`, `ram_rdata` is written into the 2-entry output buffer at the next edge.
- **Output buffer**
  - Two registers kept in FIFO order. `out_data` is always the head, and `out_valid = (ob_cnt != 0)`.
  - On `out_fire = out_valid & out_ready` the head pops. A pop and a capture in the same cycle are both honoured.
- **Flush**
  - At the edge where `flush = 1`: `wptr`, `rptr`, `ram_cnt`, `rd_pend` and `ob_cnt` clear to 0. Any in-flight read data is discarded.
  - `in_ready` is forced to 0 during the flush cycle. RAM contents are not cleared.
- **Overflow/underflow**
  - The block never writes when `ram_cnt = 64` and never issues when `ram_cnt = 0`.
  - Pointer wrap 63→0 is natural modulo.

## Timing
- **Reset values** (while `rst_n = 0` and at the first edge after release):
  - `in_ready = 0`, `out_valid = 0`, `out_data = 0`, `level = 0`.
  - `ram_wceb = 1`, `ram_rceb = 1`, `ram_waddr = 0`, `ram_raddr = 0`.
  - `in_ready` rises in the first cycle after `rst_n` goes high.
- **Latency** from `in_fire` in cycle 0 into an empty FIFO:
  - Read issued in cycle 1.
  - `ram_rdata` valid in cycle 2.
  - `out_valid = 1` in cycle 3.
- **Throughput:** with `out_ready` held at 1, one word per cycle in steady state. No bubbles once `ram_cnt > 0`.
- **Capacity:** 64 words in RAM plus 2 prefetched. `in_ready` deasserts only when the RAM holds 64 unread words.
- **Back-pressure:** with `out_ready = 0`, at most 2 words are prefetched and reads then stop. `out_data` stays stable while `out_valid & ~out_ready`.
- **Reset or flush mid-transfer:** takes effect at the same edge, with no partial words. `out_valid` is 0 in the following cycle.

## Test plan
- **Single word:** reset, then push one word `0xA5..` in cycle 0 → `ram_rceb` low in cycle 1, `out_valid` in cycle 3 with the same data, `level` sequence 1,1,1,1 then 0 after the pop.
- **Fill and overflow:** `out_ready = 0`, push 70 words → 66 accepted, `in_ready` low after the 66th, `level = 66`. Drain → the 66 words appear in order and `in_ready` returns.
- **Streaming wrap:** continuous push and pop of 200 incrementing words → 1 word/cycle after fill-up, correct order across the 63→0 pointer wrap, no `in_ready` drop.
- **Random back-pressure:** random `in_valid`/`out_ready` over 5000 cycles against a scoreboard → no loss, duplication or reorder; `out_data` stable while stalled; the RAM model never sees a read and a write to the same address in one cycle.
- **Flush:** flush with 10 words stored and one read in flight → next cycle `level = 0`, `out_valid = 0`; a new word then appears 3 cycles after its push.
- **Reset mid-stream:** `rst_n` low for 1 cycle during streaming → every output at its reset value, first post-reset word read from address 0.

Source files
------------

// File: rtl/tpram_fifo_ctrl.sv
// Purpose : 64x288 valid/ready FIFO built on one two-port SRAM with a 2-entry output prefetch stage.
// Latency : push in cycle 0 -> RAM read cycle 1 -> RAM data cycle 2 -> out_valid_o cycle 3; 1 word/cycle sustained.
// Backpres: in_ready_o drops only with 64 unread words in RAM; with out_ready_i low, reads stop after 2 prefetched words.
// Ports   : clk_i/rst_n_i (sync, active-low), flush_i; producer in_valid_i/in_ready_o/in_data_i;
//           consumer out_valid_o/out_ready_i/out_data_o; level_o = RAM + in-flight + prefetched entries;
//           RAM side ram_wceb_o/ram_waddr_o/ram_wdata_o, ram_rceb_o/ram_raddr_o, ram_rdata_i (1-cycle read latency).
module tpram_fifo_ctrl #(
  parameter int DW    = 288,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [6:0]    level_o,
  output logic          ram_wceb_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic          ram_rceb_o,
  output logic [AW-1:0] ram_raddr_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic [DW-1:0] ob0_q, ob0_d;
  logic [DW-1:0] ob1_q, ob1_d;
  logic          in_ready_q, in_ready_d;

  logic          in_fire;
  logic          out_fire;
  logic          issue;
  logic [2:0]    ob_after;
  logic [1:0]    widx;

  // Ready is registered, but a flush or reset cycle must not accept a word
  // that would be lost when the pointers clear at the same edge.
  assign in_ready_o  = in_ready_q & ~flush_i & rst_n_i;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_valid_o = (ob_cnt_q != 2'd0);
  assign out_fire    = out_valid_o & out_ready_i;
  assign out_data_o  = ob0_q;

  // Prefetch occupancy once this cycle's pop and the pending capture settle;
  // a new read is only allowed if its data will still have a slot.
  assign ob_after = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, out_fire};
  assign issue    = rst_n_i & ~flush_i & (ram_cnt_q != '0) & (ob_after <= 3'd1);

  assign ram_wceb_o  = ~in_fire;
  assign ram_waddr_o = wptr_q;
  assign ram_wdata_o = in_data_i;
  assign ram_rceb_o  = ~issue;
  assign ram_raddr_o = rptr_q;

  assign level_o = ram_cnt_q + CW'(rd_pend_q) + CW'(ob_cnt_q);

  // Slot receiving captured data, counted after this cycle's pop shifted the buffer.
  assign widx = ob_cnt_q - {1'b0, out_fire};

  always_comb begin
    wptr_d     = wptr_q + AW'(in_fire);
    rptr_d     = rptr_q + AW'(issue);
    ram_cnt_d  = ram_cnt_q + CW'(in_fire) - CW'(issue);
    rd_pend_d  = issue;
    ob_cnt_d   = ob_after[1:0];
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    if (out_fire) begin
      ob0_d = ob1_q;
    end
    if (rd_pend_q) begin
      if (widx == 2'd0) begin
        ob0_d = ram_rdata_i;
      end else begin
        ob1_d = ram_rdata_i;
      end
    end
    if (flush_i) begin
      // In-flight read data is dropped; RAM contents are left as they are.
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      rd_pend_d = 1'b0;
      ob_cnt_d  = 2'd0;
    end
    in_ready_d = (ram_cnt_d < CW'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_pend_q  <= rd_pend_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_tpram_fifo_ctrl.sv
// Purpose : directed and random checks of tpram_fifo_ctrl against a behavioural two-port RAM.
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpres: bench drives in_valid/out_ready patterns and tracks expected contents in a queue.
module tb_tpram_fifo_ctrl;

  localparam int DW = 288;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [6:0]    level;
  logic          ram_wceb;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_rceb;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:63];
  int            coll = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tpram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(64)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .level_o     (level),
    .ram_wceb_o  (ram_wceb),
    .ram_waddr_o (ram_waddr),
    .ram_wdata_o (ram_wdata),
    .ram_rceb_o  (ram_rceb),
    .ram_raddr_o (ram_raddr),
    .ram_rdata_i (ram_rdata)
  );

  // Behavioural SRAM: registered read, data valid the cycle after rceb low.
  always @(posedge clk) begin
    if (!ram_wceb) mem[ram_waddr] <= ram_wdata;
    if (!ram_rceb) ram_rdata <= mem[ram_raddr];
  end

  always @(negedge clk) begin
    if (!ram_wceb && !ram_rceb && (ram_waddr == ram_raddr)) coll = coll + 1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] a5;
  logic [DW-1:0] d5a;
  logic [DW-1:0] tmp;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] sb [$];

  initial begin
    int acc, got, pushed, popped, first, last, bad, drops;
    int rand_bad, stall_bad, level_bad, seq;
    logic prev_stall, fire_in, fire_out;

    a5  = {36{8'hA5}};
    d5a = {36{8'h5A}};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // ---------------- reset values ----------------
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_wceb", ram_wceb, 1);
    chk("rst_rceb", ram_rceb, 1);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_raddr", ram_raddr, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_c0", in_ready, 0);
    next_cycle();
    @(negedge clk);
    chk("rel_in_ready_c1", in_ready, 1);

    // ---------------- single word ----------------
    next_cycle();
    in_valid = 1'b1; in_data = a5;
    @(negedge clk);
    chk("sw_wceb", ram_wceb, 0);
    chk("sw_waddr", ram_waddr, 0);
    chk("sw_level0", level, 0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sw_rceb_c1", ram_rceb, 0);
    chk("sw_raddr_c1", ram_raddr, 0);
    chk("sw_level_c1", level, 1);
    next_cycle();
    @(negedge clk);
    chk("sw_level_c2", level, 1);
    chk("sw_oval_c2", out_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("sw_oval_c3", out_valid, 1);
    chk("sw_data_c3", out_data, a5);
    chk("sw_level_c3", level, 1);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("sw_data_c4", out_data, a5);
    chk("sw_level_c4", level, 1);
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("sw_level_pop", level, 0);
    chk("sw_oval_pop", out_valid, 0);

    // ---------------- fill and overflow ----------------
    acc = 0;
    for (int i = 0; i < 70; i++) begin
      next_cycle();
      in_valid = 1'b1; in_data = DW'(acc);
      @(negedge clk);
      if (in_ready) acc++;
    end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", acc, 66);
    chk("fill_level", level, 66);
    chk("fill_in_ready", in_ready, 0);
    got = 0;
    for (int i = 0; i < 200 && got < 66; i++) begin
      next_cycle();
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        chk("fill_drain_data", out_data, DW'(got));
        got++;
      end
    end
    chk("fill_drain_cnt", got, 66);
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("fill_in_ready_back", in_ready, 1);
    chk("fill_level_empty", level, 0);

    // ---------------- streaming with pointer wrap ----------------
    pushed = 0; popped = 0; first = -1; last = -1; bad = 0; drops = 0;
    for (int c = 0; c < 400 && popped < 200; c++) begin
      next_cycle();
      in_valid = (pushed < 200); in_data = DW'(1000 + pushed); out_ready = 1'b1;
      @(negedge clk);
      if (in_valid && !in_ready) drops++;
      if (in_valid && in_ready) pushed++;
      if (out_valid) begin
        if (out_data !== DW'(1000 + popped)) bad++;
        if (first < 0) first = c;
        last = c;
        popped++;
      end
    end
    next_cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_popped", popped, 200);
    chk("stream_order_errs", bad, 0);
    chk("stream_ready_drops", drops, 0);
    chk("stream_first_out", first, 3);
    chk("stream_span", last - first, 199);

    // ---------------- random back-pressure ----------------
    rand_bad = 0; stall_bad = 0; level_bad = 0; seq = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 5000; c++) begin
      next_cycle();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      tmp = {9{$urandom}};
      tmp[31:0] = seq;
      in_data = tmp;
      @(negedge clk);
      if (prev_stall && (out_data !== prev_data)) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (level !== 7'(sb.size())) level_bad++;
      fire_in = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (out_valid && ((sb.size() == 0) || (out_data !== sb[0]))) rand_bad++;
      if (fire_out && sb.size() != 0) void'(sb.pop_front());
      if (fire_in) begin
        sb.push_back(in_data);
        seq++;
      end
    end
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      next_cycle();
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (out_data !== sb[0]) rand_bad++;
        void'(sb.pop_front());
      end
    end
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("rand_data_errs", rand_bad, 0);
    chk("rand_stall_errs", stall_bad, 0);
    chk("rand_level_errs", level_bad, 0);
    chk("rand_left", sb.size(), 0);
    chk("rand_level_end", level, 0);
    chk("ram_rw_collisions", coll, 0);

    // ---------------- flush with read in flight ----------------
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      in_valid = 1'b1; in_data = DW'(100 + i);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      in_valid = 1'b0;
    end
    @(negedge clk);
    chk("fl_level10", level, 10);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_pop_data", out_data, DW'(100));
    chk("fl_issue", ram_rceb, 0);
    next_cycle();
    out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", in_ready, 0);
    chk("fl_no_issue", ram_rceb, 1);
    next_cycle();
    flush = 1'b0; in_valid = 1'b1; in_data = DW'(32'hBEEF);
    @(negedge clk);
    chk("fl_level0", level, 0);
    chk("fl_oval0", out_valid, 0);
    chk("fl_in_ready_back", in_ready, 1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_oval_c1", out_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("fl_oval_c2", out_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("fl_oval_c3", out_valid, 1);
    chk("fl_data_c3", out_data, DW'(32'hBEEF));
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("fl_level_end", level, 0);

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      in_valid = 1'b1; out_ready = 1'b1; in_data = DW'(500 + i);
    end
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_wceb_in_rst", ram_wceb, 1);
    chk("mr_rceb_in_rst", ram_rceb, 1);
    chk("mr_ready_in_rst", in_ready, 0);
    next_cycle();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("mr_oval", out_valid, 0);
    chk("mr_odata", out_data, 0);
    chk("mr_level", level, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_waddr", ram_waddr, 0);
    chk("mr_raddr", ram_raddr, 0);
    chk("mr_wceb", ram_wceb, 1);
    chk("mr_rceb", ram_rceb, 1);
    next_cycle();
    in_valid = 1'b1; in_data = d5a;
    @(negedge clk);
    chk("mr_push_ready", in_ready, 1);
    chk("mr_push_waddr", ram_waddr, 0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_rd_rceb", ram_rceb, 0);
    chk("mr_rd_raddr", ram_raddr, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("mr_oval_c3", out_valid, 1);
    chk("mr_data_c3", out_data, d5a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
